btn_conditioner: RTL
====================

// Module: btn_conditioner
// PURPOSE
//   Conditions the five raw push-buttons (C/U/D/L/R) before they reach
//   block_controller and the reset logic. Each button gets a 2-flop
//   synchroniser, a counter-based debouncer, a clean level output, and
//   one-cycle press/release pulses. Sits between the board pins and the game logic.
// PARAMETERS
//   NUM_BTN        5           number of independent button channels
//   DB_CYCLES      1_000_000   stable cycles required to accept an edge (10 ms @100 MHz); >=2
//   REPEAT_DELAY   50_000_000  held cycles before first auto-repeat pulse (macro only)
//   REPEAT_PERIOD  10_000_000  cycles between later auto-repeat pulses (macro only)
// PORTS
//   clk          in   1        system clock, 100 MHz
//   rst_n        in   1        asynchronous, active-low reset
//   btn_raw      in   NUM_BTN  asynchronous button pins, 1 = pressed
//   btn_level    out  NUM_BTN  debounced level, 1 = pressed
//   btn_press    out  NUM_BTN  1-cycle pulse on accepted press (and on repeats)
//   btn_release  out  NUM_BTN  1-cycle pulse on accepted release
// BEHAVIOUR
//   - rst_n low: all FSMs go to IDLE at once; counters and sync flops clear;
//     all outputs 0. Reset mid-debounce discards the partial count.
//   - Channels are fully independent. Simultaneous presses give pulses in the same cycle.
//   - Sync: s1<=btn_raw; s2<=s1. The FSM uses only s2.
//   - All outputs are registered. Counters are $clog2(max param)+1 bits. There is no wrap.
//   - Per-channel FSM:
//     IDLE:     level=0; s2=1 -> PRESS_WAIT, cnt<=0
//     PRESS_WAIT: s2=0 -> IDLE (bounce, no pulse); cnt==DB_CYCLES-1 -> HELD,
//               level<=1, press<=1 for one cycle; else cnt++
//     HELD:     level=1; s2=0 -> RELEASE_WAIT, cnt<=0
//     RELEASE_WAIT: level stays 1; s2=1 -> HELD (no pulse, repeat count kept);
//               cnt==DB_CYCLES-1 -> IDLE, level<=0, release<=1 for one cycle; else cnt++
//   - Latency: edge 0 is the first edge sampling raw=1, with raw held stable.
//     The press pulse and level rise are visible after edge DB_CYCLES+2.
//     Release is symmetric: falls after edge DB_CYCLES+2 from the first edge sampling raw=0.
//   - A bounce shorter than DB_CYCLES cycles never produces a pulse or a level change.
//   - press and release are never high together on one channel.
// CONFIGURATION
//   BTN_AUTOREPEAT_EN defined:
//     - On entry to HELD, rpt<=0. rpt counts in HELD and freezes in RELEASE_WAIT.
//     - When rpt==REPEAT_DELAY-1: press<=1 for one cycle, rpt<=0, phase<=periodic.
//     - Later pulses come each time rpt==REPEAT_PERIOD-1.
//     - Going to IDLE clears the phase.
//   BTN_AUTOREPEAT_EN undefined:
//     - No repeat counter is synthesised.
//     - press fires only on the PRESS_WAIT->HELD transition.
// TESTING (bench uses DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
//   1 Reset: rst_n=0 mid-debounce with raw=1 -> all outputs 0 immediately;
//     after release of rst_n, count restarts and press comes after edge 6.
//   2 Clean press: raw[1] 0->1 held -> press[1] high for exactly 1 cycle after edge 6;
//     level[1]=1; other bits stay 0.
//   3 Bounce: raw[2] high 3 cycles, low 1, high held -> no pulse until
//     the 4-cycle-stable window completes; exactly one press.
//   4 Release glitch: in HELD, raw[0] low 2 cycles then high -> level stays 1,
//     no release, no press; a later sustained low gives one release after edge 6.
//   5 Simultaneous: raw[4:0]=5'b11111 in one cycle -> btn_press=5'b11111 for one cycle.
//   6 Auto-repeat (macro on): hold raw[3] -> press at entry, again 8 cycles later,
//     then every 3 cycles; macro off -> single press only.

Source files
------------

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Conditions NUM_BTN raw push-buttons. Each channel has a 2-flop
//            synchroniser, a counter-based debouncer (DB_CYCLES stable
//            cycles), a registered clean level and registered one-cycle
//            press/release pulses.
// Ports    : clk          in   1        system clock
//            rst_n        in   1        asynchronous, active-low reset
//            btn_raw      in   NUM_BTN  asynchronous button pins, 1 = pressed
//            btn_level    out  NUM_BTN  debounced level, 1 = pressed
//            btn_press    out  NUM_BTN  1-cycle pulse on accepted press/repeat
//            btn_release  out  NUM_BTN  1-cycle pulse on accepted release
// Config   : BTN_AUTOREPEAT_EN - when defined, a held button emits a press
//            pulse after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
//            When undefined no repeat counter exists.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int NUM_BTN       = 5,
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    // One counter width covers every terminal count so no counter can wrap.
    localparam int c_max_a = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
    localparam int c_max   = (c_max_a > REPEAT_PERIOD) ? c_max_a : REPEAT_PERIOD;
    localparam int c_cnt_w = $clog2(c_max) + 1;

    localparam logic [c_cnt_w-1:0] c_db_last = c_cnt_w'(DB_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_zero    = '0;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Two-flop synchroniser shared by all channels; only r_s2 is used downstream.
    logic [NUM_BTN-1:0] r_s1;
    logic [NUM_BTN-1:0] r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn_raw;
            r_s2 <= r_s1;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        state_t               r_state;
        state_t               w_state_next;
        logic [c_cnt_w-1:0]   r_cnt;
        logic [c_cnt_w-1:0]   w_cnt_next;
        logic                 r_level;
        logic                 w_level_next;
        logic                 r_press;
        logic                 w_press_next;
        logic                 r_release;
        logic                 w_release_next;
        logic                 w_s2;
`ifdef BTN_AUTOREPEAT_EN
        localparam logic [c_cnt_w-1:0] c_dly_last = c_cnt_w'(REPEAT_DELAY - 1);
        localparam logic [c_cnt_w-1:0] c_per_last = c_cnt_w'(REPEAT_PERIOD - 1);
        logic [c_cnt_w-1:0]   r_rpt;
        logic [c_cnt_w-1:0]   w_rpt_next;
        // 0: waiting for the first repeat, 1: periodic repeats
        logic                 r_phase;
        logic                 w_phase_next;
`endif

        assign w_s2 = r_s2[g];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= IDLE;
                r_cnt     <= c_zero;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                r_rpt     <= c_zero;
                r_phase   <= 1'b0;
`endif
            end else begin
                r_state   <= w_state_next;
                r_cnt     <= w_cnt_next;
                r_level   <= w_level_next;
                r_press   <= w_press_next;
                r_release <= w_release_next;
`ifdef BTN_AUTOREPEAT_EN
                r_rpt     <= w_rpt_next;
                r_phase   <= w_phase_next;
`endif
            end
        end

        always_comb begin
            w_state_next   = r_state;
            w_cnt_next     = r_cnt;
            w_level_next   = r_level;
            w_press_next   = 1'b0;
            w_release_next = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            w_rpt_next     = r_rpt;
            w_phase_next   = r_phase;
`endif
            case (r_state)
                IDLE: begin
                    w_level_next = 1'b0;
                    if (w_s2) begin
                        w_state_next = PRESS_WAIT;
                        w_cnt_next   = c_zero;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_s2) begin
                        // Bounce: abandon the attempt silently.
                        w_state_next = IDLE;
                    end else if (r_cnt == c_db_last) begin
                        w_state_next = HELD;
                        w_level_next = 1'b1;
                        w_press_next = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        w_rpt_next   = c_zero;
`endif
                    end else begin
                        w_cnt_next = r_cnt + c_one;
                    end
                end
                HELD: begin
                    w_level_next = 1'b1;
                    if (!w_s2) begin
                        w_state_next = RELEASE_WAIT;
                        w_cnt_next   = c_zero;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (r_rpt == (r_phase ? c_per_last : c_dly_last)) begin
                        w_press_next = 1'b1;
                        w_rpt_next   = c_zero;
                        w_phase_next = 1'b1;
                    end else begin
                        w_rpt_next = r_rpt + c_one;
                    end
`endif
                end
                RELEASE_WAIT: begin
                    // Repeat state is left untouched here so a release glitch
                    // only pauses the auto-repeat timing.
                    if (w_s2) begin
                        w_state_next = HELD;
                    end else if (r_cnt == c_db_last) begin
                        w_state_next   = IDLE;
                        w_level_next   = 1'b0;
                        w_release_next = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        w_phase_next   = 1'b0;
`endif
                    end else begin
                        w_cnt_next = r_cnt + c_one;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end

        assign btn_level[g]   = r_level;
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_release;
    end

endmodule
`default_nettype wire
